// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, single-key debounce, press/release
// tracking, and a two-digit hex history for the seven-segment multiplexer.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 48000,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [7:0] digits,
  output logic [3:0] key_code,
  output logic       key_pulse
);

  localparam int SLOT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        rs1_n;
  logic [3:0]        rs_n;
  logic [3:0]        rows;
  logic [SLOT_W-1:0] slot_cnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic [1:0]        lat_row;
  logic [1:0]        lat_col;

  assign rows = ~rs_n;

  // Keypad legend: row r, column c.
  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] cn);
    logic [1:0] idx;
    idx = 2'd0;
    case (cn)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Row 0 has the highest priority when several rows are low together.
  function automatic logic [1:0] low_row(input logic [3:0] rw);
    logic [1:0] idx;
    if (rw[0])      idx = 2'd0;
    else if (rw[1]) idx = 2'd1;
    else if (rw[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] row_onehot(input logic [1:0] r);
    return 4'b0001 << r;
  endfunction

  function automatic logic [3:0] rotate(input logic [3:0] cn);
    return {cn[2:0], cn[3]};
  endfunction

  // NOTE: all state, including the synchronizer, uses non-blocking assignments
  // and a synchronous reset so every flop lands on its reset value together.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_n     <= 4'b1111;
      rs_n      <= 4'b1111;
      state     <= SCAN;
      col_n     <= 4'b1110;
      slot_cnt  <= '0;
      deb_cnt   <= '0;
      lat_row   <= 2'd0;
      lat_col   <= 2'd0;
      digits    <= 8'h00;
      key_code  <= 4'h0;
      key_pulse <= 1'b0;
    end else begin
      rs1_n     <= row_n;
      rs_n      <= rs1_n;
      key_pulse <= 1'b0;

      case (state)
        SCAN: begin
          // Rows are only looked at on the last slot cycle, which leaves the
          // synchronizer time to settle after a column change.
          if (slot_cnt == SLOT_LAST) begin
            if (rows != 4'b0000) begin
              lat_row <= low_row(rows);
              lat_col <= col_index(col_n);
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              col_n    <= rotate(col_n);
              slot_cnt <= '0;
            end
          end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
          end
        end

        DEBOUNCE: begin
          if (rows == row_onehot(lat_row)) begin
            if (deb_cnt == DEB_LAST) begin
              digits    <= {digits[3:0], key_lookup(lat_row, lat_col)};
              key_code  <= key_lookup(lat_row, lat_col);
              key_pulse <= 1'b1;
              deb_cnt   <= '0;
              state     <= HELD;
            end else begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end else begin
            deb_cnt  <= '0;
            col_n    <= rotate(col_n);
            slot_cnt <= '0;
            state    <= SCAN;
          end
        end

        HELD: begin
          // Any activity on the held column, including extra keys, restarts
          // the release count; nothing new is registered from here.
          if (rows == 4'b0000) begin
            if (deb_cnt == DEB_LAST) begin
              deb_cnt  <= '0;
              col_n    <= rotate(col_n);
              slot_cnt <= '0;
              state    <= SCAN;
            end else begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end else begin
            deb_cnt <= '0;
          end
        end

        default: begin
          deb_cnt  <= '0;
          slot_cnt <= '0;
          state    <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives row_n from the
// pressed-key set, and expected digits come from a shift-history model.
module tb_keypad_scanner;

  localparam int SCAN = 4;
  localparam int DEB  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [7:0] digits;
  logic [3:0] key_code;
  logic       key_pulse;

  logic [15:0] pressed;
  int          errors = 0;
  int          checks = 0;
  int          pulse_cnt = 0;
  int          double_cnt = 0;
  logic        prev_pulse = 1'b0;
  logic [7:0]  exp_digits;

  // Keypad legend indexed by r*4+c.
  logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .digits    (digits),
    .key_code  (key_code),
    .key_pulse (key_pulse)
  );

  // A closed switch pulls its row low only while its column is driven low.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_pulse) begin
      pulse_cnt <= pulse_cnt + 1;
      if (prev_pulse) double_cnt <= double_cnt + 1;
    end
    prev_pulse <= key_pulse;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_pulse(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick(1);
      if (key_pulse) got = 1'b1;
    end
  endtask

  // Aligns to the first sample after col_n switches to target.
  task automatic wait_col(input logic [3:0] target, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && col_n == target; i++) tick(1);
    for (int i = 0; i < budget && !got; i++) begin
      tick(1);
      if (col_n == target) got = 1'b1;
    end
  endtask

  initial begin
    bit   got;
    int   p;
    int   r;
    int   c;
    int   idx;
    int   nb;

    pressed = '0;
    reset   = 1'b1;
    tick(3);
    check("reset_col", col_n, 4'b1110);
    check("reset_digits", digits, 8'h00);
    check("reset_code", key_code, 4'h0);
    check("reset_pulse", key_pulse, 1'b0);
    reset      = 1'b0;
    exp_digits = 8'h00;

    // Idle scan: each column held for SCAN cycles, in rotation order.
    wait_col(4'b1101, 40, got);
    check("scan_align", got, 1'b1);
    tick(SCAN - 1);
    check("scan_hold", col_n, 4'b1101);
    tick(1);
    check("scan_c2", col_n, 4'b1011);
    tick(SCAN);
    check("scan_c3", col_n, 4'b0111);
    tick(SCAN);
    check("scan_wrap", col_n, 4'b1110);
    check("scan_no_pulse", pulse_cnt, 0);

    // '6' pressed right as its column is driven: slot end, then debounce.
    wait_col(4'b1011, 40, got);
    check("k6_align", got, 1'b1);
    pressed[6] = 1'b1;
    tick(11);
    check("k6_early", key_pulse, 1'b0);
    tick(1);
    check("k6_pulse", key_pulse, 1'b1);
    exp_digits = {exp_digits[3:0], 4'h6};
    check("k6_code", key_code, 4'h6);
    check("k6_digits", digits, exp_digits);
    check("k6_col_held", col_n, 4'b1011);
    p = pulse_cnt;
    tick(200);
    check("k6_hold_one_pulse", pulse_cnt, p);
    check("k6_hold_col", col_n, 4'b1011);
    pressed[6] = 1'b0;
    tick(9);
    check("k6_release_wait", col_n, 4'b1011);
    tick(1);
    check("k6_rescan", col_n, 4'b0111);

    // 'A' after '6'.
    pressed[3] = 1'b1;
    wait_pulse(100, got);
    check("kA_got", got, 1'b1);
    exp_digits = {exp_digits[3:0], 4'hA};
    check("kA_code", key_code, 4'hA);
    check("kA_digits", digits, exp_digits);
    pressed[3] = 1'b0;
    tick(30);
    check("two_pulses", pulse_cnt, 2);

    // Bouncing '5': short contacts never reach the debounce count.
    p = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      pressed[5] = ~pressed[5];
      tick(3);
    end
    check("bounce_no_pulse", pulse_cnt, p);
    pressed[5] = 1'b1;
    wait_pulse(100, got);
    check("k5_got", got, 1'b1);
    exp_digits = {exp_digits[3:0], 4'h5};
    check("k5_low_nibble", digits[3:0], 4'h5);
    check("k5_digits", digits, exp_digits);
    tick(20);
    check("k5_single", pulse_cnt, p + 1);
    pressed[5] = 1'b0;
    tick(30);

    // '9' pressed while '1' is held is ignored until '1' is released.
    pressed[0] = 1'b1;
    wait_pulse(100, got);
    check("k1_got", got, 1'b1);
    exp_digits = {exp_digits[3:0], 4'h1};
    check("k1_code", key_code, 4'h1);
    pressed[10] = 1'b1;
    p = pulse_cnt;
    tick(100);
    check("k9_blocked", pulse_cnt, p);
    pressed[0] = 1'b0;
    wait_pulse(200, got);
    check("k9_got", got, 1'b1);
    exp_digits = {exp_digits[3:0], 4'h9};
    check("k9_code", key_code, 4'h9);
    check("k9_digits", digits, 8'h19);
    check("k9_model", digits, exp_digits);
    pressed[10] = 1'b0;
    tick(30);

    // Second row in the latched column mid-debounce aborts back to scanning.
    wait_col(4'b1110, 40, got);
    check("abort_align", got, 1'b1);
    p = pulse_cnt;
    pressed[0] = 1'b1;
    tick(6);
    pressed[8] = 1'b1;
    tick(3);
    check("abort_col", col_n, 4'b1101);
    check("abort_pulse", key_pulse, 1'b0);
    pressed[0] = 1'b0;
    pressed[8] = 1'b0;
    tick(40);
    check("abort_no_reg", pulse_cnt, p);

    // One-cycle reset during the debounce of 'F'.
    wait_col(4'b1011, 40, got);
    check("kF_align", got, 1'b1);
    pressed[14] = 1'b1;
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midreset_col", col_n, 4'b1110);
    check("midreset_digits", digits, 8'h00);
    check("midreset_code", key_code, 4'h0);
    check("midreset_pulse", key_pulse, 1'b0);
    exp_digits = 8'h00;
    p = pulse_cnt;
    wait_pulse(200, got);
    check("kF_got", got, 1'b1);
    exp_digits = {exp_digits[3:0], 4'hF};
    check("kF_code", key_code, 4'hF);
    check("kF_digits", digits, exp_digits);
    tick(50);
    check("kF_single", pulse_cnt, p + 1);
    pressed[14] = 1'b0;
    tick(30);

    // Random keys, optional contact bounce, random hold time.
    for (int n = 0; n < 10; n++) begin
      r   = int'($urandom_range(3));
      c   = int'($urandom_range(3));
      idx = r * 4 + c;
      p   = pulse_cnt;
      if ($urandom_range(1) == 1) begin
        nb = 2 * int'($urandom_range(4, 1));
        for (int j = 0; j < nb; j++) begin
          pressed[idx] = ~pressed[idx];
          tick(int'($urandom_range(3, 1)));
        end
      end
      pressed[idx] = 1'b1;
      wait_pulse(300, got);
      check($sformatf("rnd%0d_got", n), got, 1'b1);
      exp_digits = {exp_digits[3:0], key_map[idx]};
      check($sformatf("rnd%0d_code", n), key_code, key_map[idx]);
      check($sformatf("rnd%0d_digits", n), digits, exp_digits);
      tick(int'($urandom_range(40)));
      check($sformatf("rnd%0d_single", n), pulse_cnt, p + 1);
      pressed[idx] = 1'b0;
      tick(30);
    end

    check("no_back_to_back_pulse", double_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad, debounces one key press at a time, and registers each new press exactly once.
- Holds the two most recent hex digits as an 8-bit value. The downstream two-digit seven-segment multiplexer consumes this value directly: [7:4] drives the left display, [3:0] the right.
- Sits directly upstream of the display multiplexer and replaces the slide-switch input path.
- Clocked from the 48 MHz internal oscillator domain.

Parameters:
- SCAN_CYCLES, 48000, clock cycles each column stays driven during scanning (1 ms at 48 MHz); must be >= 4.
- DEBOUNCE_CYCLES, 480000, consecutive stable cycles needed to accept a press or a release (10 ms); must be >= 2.

Ports:
- clk  in  1  system clock, 48 MHz.
- reset  in  1  reset, synchronous, active-high.
- row_n  in  4  keypad row inputs; active-low, externally pulled up, asynchronous.
- col_n  out  4  keypad column drives; active-low one-hot, registered.
- digits  out  8  [3:0] newest key, [7:4] previous key; registered.
- key_code  out  4  hex value of the last accepted key; registered.
- key_pulse  out  1  one-cycle strobe on the cycle digits/key_code update.

Behaviour:
- Reset values: col_n=4'b1110, digits=8'h00, key_code=4'h0, key_pulse=0, state=SCAN, all counters 0, synchronizer flops all 1.
- Synchronizer:
  - row_n passes through a 2-flop synchronizer; all logic uses the synchronized value rs_n.
  - rows = ~rs_n.
- Key map, row index r (0..3) by column index c (0..3), c = position of the 0 in col_n:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- SCAN:
  - slot_cnt counts 0..SCAN_CYCLES-1.
  - On the cycle slot_cnt==SCAN_CYCLES-1:
    - If rows!=0, latch c and r. r is the lowest-index asserted row (priority r0 highest). Clear deb_cnt and go to DEBOUNCE; col_n holds.
    - Otherwise rotate the column: 1110 -> 1101 -> 1011 -> 0111 -> 1110. Clear slot_cnt.
  - Rows are never sampled at other slot cycles. This covers synchronizer settling after a column change.
- DEBOUNCE:
  - col_n held.
  - Each cycle where rows equals the one-hot of the latched r: deb_cnt++.
  - Any other rows value (including 0 or extra rows): clear deb_cnt, rotate to the next column, clear slot_cnt, go to SCAN.
  - When deb_cnt reaches DEBOUNCE_CYCLES-1 with rows still matching:
    - digits <= {digits[3:0], code}; key_code <= code; key_pulse=1 on the next cycle only.
    - Go to HELD with deb_cnt cleared.
- HELD:
  - col_n held.
  - rows==0: deb_cnt++. Any rows!=0: deb_cnt cleared.
  - Extra keys pressed while held are ignored: no registration, no state change.
  - When deb_cnt reaches DEBOUNCE_CYCLES-1 with rows==0: go to SCAN. Rotate to the next column and clear slot_cnt.
- Latency:
  - Press stable from cycle t (at pin, column already driven): key_pulse asserts at t+2 (sync) + DEBOUNCE_CYCLES + 1.
  - This is additional to any wait for the scan slot to end.
- key_pulse is never high in two consecutive cycles. Exactly one pulse occurs per press-release cycle, regardless of hold duration.
- Reset mid-operation (any state, any counter value): next cycle all registers return to reset values. A key held across reset is re-registered once after a fresh debounce.
- Counter widths are $clog2 of the parameter, with no wraparound beyond the terminal value.
- No combinational path from row_n to any output.

Test Plan:
- Run with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8 unless stated.
- Reset, no keys -> col_n cycles 1110,1101,1011,0111,1110 changing every 4 clks; digits=00; key_pulse never high.
- Press key at r1,c2 ('6') steadily -> scan stops with col_n=1011; one key_pulse; digits=06, key_code=6. Hold 200 clks -> no further pulses. Release -> scan resumes after 8 clean clks.
- Press '6', release, press 'A' (r0,c3), release -> two pulses total, digits=6A.
- Bounce: '5' toggles every 3 clks for 30 clks, then stable -> no pulse during bounce; exactly one pulse after 8 stable cycles; digits low nibble=5.
- Hold '1', also press '9' while in HELD, release '1' while '9' remains held -> '9' not registered while '1' held. '9' registers once only after release debounce and rescan (digits=19). During a DEBOUNCE window, two rows low in the latched column -> abort to SCAN with no pulse.
- Assert reset for 1 clk during DEBOUNCE of 'F' -> next cycle col_n=1110, digits=00, key_pulse=0. 'F' registers once after release of reset and a full debounce.
